// File: rtl/turn_pkg.sv
// Shared types and constants for the turn-request conditioner.
package turn_pkg;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_LEFT   = 2'd1,
    REQ_RIGHT  = 2'd2,
    REQ_HAZARD = 2'd3
  } req_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/turn_request_ctrl_if.sv
// Lever inputs and request outputs of the turn-request conditioner.
interface turn_request_ctrl_if;
  import turn_pkg::*;

  // Level semantics, no handshake: raw inputs are asynchronous levels,
  // left/right are registered levels, tick is a one-cycle pulse.
  logic       lever_left_raw;
  logic       lever_right_raw;
  logic       hazard_raw;
  logic       left;
  logic       right;
  logic       tick;
  req_state_t state_dbg;

  modport slave (
    input  lever_left_raw,
    input  lever_right_raw,
    input  hazard_raw,
    output left,
    output right,
    output tick,
    output state_dbg
  );

  modport master (
    output lever_left_raw,
    output lever_right_raw,
    output hazard_raw,
    input  left,
    input  right,
    input  tick,
    input  state_dbg
  );

endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one switch.
module switch_debounce
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   db_q, db_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // The counter only advances while the synchronized level disagrees;
  // any agreeing cycle restarts the qualification window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_bit != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_bit;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/turn_request_ctrl.sv
// Conditions lever/hazard switches into left/right request levels with a
// minimum flash duration, and provides the sequencer step tick.
module turn_request_ctrl
  import turn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8,
  parameter int MIN_TICKS       = 3
) (
  input  logic                clk,
  input  logic                reset,
  turn_request_ctrl_if.slave  bus
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = ($clog2(MIN_TICKS + 1) > 0) ? $clog2(MIN_TICKS + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MIN_TICKS);
  localparam logic [HW-1:0] HOLD_EXIT = HW'(MIN_TICKS - 1);

  logic left_db, right_db, haz_db;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left_db (
    .clk   (clk),
    .reset (reset),
    .raw_i (bus.lever_left_raw),
    .db_o  (left_db)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right_db (
    .clk   (clk),
    .reset (reset),
    .raw_i (bus.lever_right_raw),
    .db_o  (right_db)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_haz_db (
    .clk   (clk),
    .reset (reset),
    .raw_i (bus.hazard_raw),
    .db_o  (haz_db)
  );

  req_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q;
  logic          left_q, right_q;
  logic          own_db;

  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  assign own_db = (state_q == REQ_LEFT) ? left_db : right_db;

  // A single-side request only leaves on a tick once the minimum sweep
  // count is met and its own lever is released; the other lever is ignored.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      REQ_IDLE: begin
        hold_d = '0;
        if (haz_db) begin
          state_d = REQ_HAZARD;
        end else if (left_db && !right_db) begin
          state_d = REQ_LEFT;
        end else if (right_db && !left_db) begin
          state_d = REQ_RIGHT;
        end
      end
      REQ_LEFT, REQ_RIGHT: begin
        if (haz_db) begin
          state_d = REQ_HAZARD;
        end else if (tick_q) begin
          if ((hold_q >= HOLD_EXIT) && !own_db) begin
            state_d = REQ_IDLE;
          end
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      REQ_HAZARD: begin
        hold_d = '0;
        if (tick_q && !haz_db) begin
          state_d = REQ_IDLE;
        end
      end
      default: begin
        state_d = REQ_IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REQ_IDLE;
      hold_q  <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      tick_q  <= (div_q == DIV_LAST);
      left_q  <= (state_d == REQ_LEFT)  || (state_d == REQ_HAZARD);
      right_q <= (state_d == REQ_RIGHT) || (state_d == REQ_HAZARD);
    end
  end

  assign bus.left      = left_q;
  assign bus.right     = right_q;
  assign bus.tick      = tick_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_turn_request_ctrl.sv
// Directed bench for turn_request_ctrl: output-change scoreboard with
// hand-computed {left,right} values and cycle numbers counted from reset release.
module tb_turn_request_ctrl;
  import turn_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  turn_request_ctrl_if bus ();

  turn_request_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .TICK_DIV        (8),
    .MIN_TICKS       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [17:0] exp_q[$];       // {left,right, cycle[15:0]}
  logic [15:0] tick_exp_q[$];  // cycles at which tick is expected high
  logic        tick_en = 1'b0;
  logic [1:0]  prev_lr = 2'b00;
  logic [1:0]  lr_now;
  logic [17:0] ev;
  logic [15:0] tev;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_lr(input logic [1:0] lr, input int at);
    exp_q.push_back({lr, 16'(at)});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_lr = 2'b00;
    end else begin
      lr_now = {bus.left, bus.right};
      if (lr_now != prev_lr) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL lr_unexpected: got lr=%b at cycle %0d, expected no change", lr_now, cyc);
        end else begin
          ev = exp_q.pop_front();
          check("lr_value", int'(lr_now), int'(ev[17:16]));
          check("lr_cycle", cyc, int'(ev[15:0]));
        end
        prev_lr = lr_now;
      end
      if (tick_en && bus.tick) begin
        if (tick_exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tick_unexpected: got tick at cycle %0d, expected none", cyc);
        end else begin
          tev = tick_exp_q.pop_front();
          check("tick_cycle", cyc, int'(tev));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_raw(input logic l, input logic r, input logic h);
    bus.lever_left_raw  = l;
    bus.lever_right_raw = r;
    bus.hazard_raw      = h;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reset held 3 cycles with all raw inputs high; returns at the release
  // negedge, where cyc is 0 and the next rising edge is cycle 1.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    set_raw(1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_left",  int'(bus.left),  0);
    check("rst_right", int'(bus.right), 0);
    check("rst_tick",  int'(bus.tick),  0);
    check("rst_state", int'(bus.state_dbg), int'(REQ_IDLE));
    reset = 1'b0;
    set_raw(1'b0, 1'b0, 1'b0);
  endtask

  task automatic end_scn(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_raw(1'b0, 1'b0, 1'b0);

    // 1: reset values and tick cadence
    do_reset();
    tick_en = 1'b1;
    tick_exp_q.push_back(16'd8);
    tick_exp_q.push_back(16'd16);
    tick_exp_q.push_back(16'd24);
    tick_exp_q.push_back(16'd32);
    wait_to(36);
    tick_en = 1'b0;
    check("tick_pending", tick_exp_q.size(), 0);
    end_scn("scn1_pending");

    // 2: bounce rejection, then a stable hold (sampled at edge 41, left at 47)
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wait_to(2 * i);
      bus.lever_left_raw = (i % 2 == 0);
    end
    wait_to(40);
    check("bounce_left", int'(bus.left), 0);
    bus.lever_left_raw = 1'b1;
    expect_lr(2'b10, 47);
    wait_to(50);
    bus.lever_left_raw = 1'b0;
    expect_lr(2'b00, 65);
    wait_to(75);
    end_scn("scn2_pending");

    // 3: short tap still flashes through three ticks (seen at 9, 17, 25)
    do_reset();
    bus.lever_left_raw = 1'b1;
    expect_lr(2'b10, 7);
    expect_lr(2'b00, 25);
    wait_to(10);
    bus.lever_left_raw = 1'b0;
    wait_to(32);
    end_scn("scn3_pending");

    // 4: long right hold; debounced release at 66, next tick seen at 73
    do_reset();
    bus.lever_right_raw = 1'b1;
    expect_lr(2'b01, 7);
    expect_lr(2'b00, 73);
    wait_to(60);
    bus.lever_right_raw = 1'b0;
    wait_to(80);
    end_scn("scn4_pending");

    // 5: hazard overrides a left request, exits on the tick after release
    do_reset();
    bus.lever_left_raw = 1'b1;
    expect_lr(2'b10, 7);
    expect_lr(2'b11, 17);
    expect_lr(2'b00, 41);
    wait_to(10);
    bus.hazard_raw = 1'b1;
    wait_to(30);
    bus.hazard_raw     = 1'b0;
    bus.lever_left_raw = 1'b0;
    wait_to(48);
    end_scn("scn5_pending");

    // 6: both levers is no request; releasing left leaves a right request,
    //    then an asynchronous reset clears it without a clock edge
    do_reset();
    bus.lever_left_raw  = 1'b1;
    bus.lever_right_raw = 1'b1;
    wait_to(30);
    check("both_left",  int'(bus.left),  0);
    check("both_right", int'(bus.right), 0);
    bus.lever_left_raw = 1'b0;
    expect_lr(2'b01, 37);
    wait_to(45);
    check("pre_rst_state", int'(bus.state_dbg), int'(REQ_RIGHT));
    end_scn("scn6_pending");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_right", int'(bus.right), 0);
    check("async_rst_left",  int'(bus.left),  0);
    check("async_rst_state", int'(bus.state_dbg), int'(REQ_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_raw(1'b0, 1'b0, 1'b0);
    wait_to(12);
    end_scn("scn6_tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
